// File: rtl/gb_conv_pkg.sv
// Shared constants and helpers for the Gray/binary conversion pipeline.
// Imported by gb_conv_stage and gray_bin_conv_pipe.
package gb_conv_pkg;

  localparam logic MODE_G2B = 1'b0;
  localparam logic MODE_B2G = 1'b1;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic logic [63:0] bin2gray(input logic [63:0] d);
    return d ^ (d >> 1);
  endfunction

endpackage

// File: rtl/gb_conv_stage.sv
// One pipeline register of the converter; resolves G2B bits [HI:LO].
// Carries the adjacency flag when GB_ADJ_CHECK_EN is defined.
module gb_conv_stage
  import gb_conv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int HI    = 7,
  parameter int LO    = 0,
  parameter bit FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             mode_i,
`ifdef GB_ADJ_CHECK_EN
  input  logic             flag_i,
  output logic             flag_o,
`endif
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             mode_o
);

  logic             valid_q;
  logic             mode_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             load;

  assign load    = !valid_q || ready_i;
  assign ready_o = load;

  // Bits above HI arrive already binary; bit i uses resolved bit i+1.
  always_comb begin
    data_d = data_i;
    if (mode_i == MODE_B2G) begin
      if (FIRST) data_d = WIDTH'(bin2gray(64'(data_i)));
    end else begin
      for (int i = WIDTH - 2; i >= 0; i--) begin
        if (i <= HI && i >= LO) data_d[i] = data_d[i+1] ^ data_i[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mode_q  <= 1'b0;
    end else if (load) begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_d;
        mode_q <= mode_i;
      end
    end
  end

`ifdef GB_ADJ_CHECK_EN
  logic flag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flag_q <= 1'b0;
    else if (load && valid_i) flag_q <= flag_i;
  end

  assign flag_o = flag_q;
`endif

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign mode_o  = mode_q;

endmodule

// File: rtl/gray_bin_conv_pipe.sv
// Pipelined bidirectional Gray/binary converter with valid/ready flow.
// Optional adjacency checker enabled by GB_ADJ_CHECK_EN.
module gray_bin_conv_pipe
  import gb_conv_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode
`ifdef GB_ADJ_CHECK_EN
  ,
  output logic             out_adj_err
`endif
);

  localparam int CH = ceil_div(WIDTH, STAGES);

  logic [STAGES:0] vld;
  logic [STAGES:0] rdy;
  logic [STAGES:0] mod;
  logic [WIDTH-1:0] dat [STAGES+1];

  assign vld[0]      = in_valid;
  assign dat[0]      = in_data;
  assign mod[0]      = in_mode;
  assign rdy[STAGES] = out_ready;
  assign in_ready    = rst_n && rdy[0];

`ifdef GB_ADJ_CHECK_EN
  logic [STAGES:0]  flg;
  logic [WIDTH-1:0] hist_q;
  logic             seen_q;
  logic             g2b_acc;

  assign g2b_acc = in_valid && in_ready && (in_mode == MODE_G2B);
  assign flg[0]  = seen_q && (in_mode == MODE_G2B) &&
                   ($countones(in_data ^ hist_q) != 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      seen_q <= 1'b0;
    end else if (g2b_acc) begin
      hist_q <= in_data;
      seen_q <= 1'b1;
    end
  end

  assign out_adj_err = flg[STAGES];
`endif

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int HI = WIDTH - 1 - s * CH;
    localparam int LO = (WIDTH - (s + 1) * CH > 0) ?
                        WIDTH - (s + 1) * CH : 0;

    gb_conv_stage #(
      .WIDTH (WIDTH),
      .HI    (HI),
      .LO    (LO),
      .FIRST (s == 0)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (vld[s]),
      .ready_o (rdy[s]),
      .data_i  (dat[s]),
      .mode_i  (mod[s]),
`ifdef GB_ADJ_CHECK_EN
      .flag_i  (flg[s]),
      .flag_o  (flg[s+1]),
`endif
      .valid_o (vld[s+1]),
      .ready_i (rdy[s+1]),
      .data_o  (dat[s+1]),
      .mode_o  (mod[s+1])
    );
  end

  assign out_valid = vld[STAGES];
  assign out_data  = dat[STAGES];
  assign out_mode  = mod[STAGES];

endmodule

// File: doc/gray_bin_conv_pipe.md
Name: gray_bin_conv_pipe

Overview:
- Parametrised, pipelined bidirectional Gray/binary code converter with valid/ready handshakes on input and output.
- Each word carries its own mode bit: Gray-to-binary (G2B) or binary-to-Gray (B2G).
- The G2B prefix-XOR chain is split across STAGES register stages so wide words close timing.
- Sits between encoder/counter-domain logic and datapath consumers; full throughput of one word per cycle under backpressure.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..64.
- STAGES, 2, pipeline register stages; legal range 1..WIDTH; sets latency.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  code word to convert.
- in_mode  input  1  0 = G2B, 1 = B2G; sampled with in_data.
- out_valid  output  1  converted word present.
- out_ready  input  1  consumer accepts the word this cycle.
- out_data  output  WIDTH  converted word.
- out_mode  output  1  mode the word was converted with.
- out_adj_err  output  1  adjacency error flag; present only with GB_ADJ_CHECK_EN.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, data registers and mode registers clear to 0. Outputs: out_valid=0, out_data=0, out_mode=0, out_adj_err=0, in_ready=0. Reset release takes effect on the next clk edge.
- Reset mid-operation discards all in-flight words. No partial word appears after release.
- Transfer rules:
  - A transfer occurs on a clk edge with valid && ready.
  - in_valid, in_data and in_mode must hold until accepted.
  - out_data and out_mode are stable while out_valid && !out_ready.
- Stage handshake: stage s loads when its valid bit is 0, or when stage s+1 takes its word (or out_ready for the last stage). in_ready = stage-0 load condition. The ready path is combinational back through the stages; there are no bubbles, and throughput is 1 word/cycle with out_ready held high.
- Latency: a word accepted at edge N presents out_valid at edge N+STAGES if there is no backpressure. Words are never reordered, dropped or duplicated.
- Arithmetic, chunk width CH = ceil(WIDTH/STAGES):
  - B2G: out = d ^ (d >> 1). Computed fully in stage 0; later stages pass it through.
  - G2B: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i]. Stage s resolves bits [WIDTH-1-s*CH : max(0, WIDTH-(s+1)*CH)] using the already-resolved higher bit from the previous stage. After stage STAGES-1 all bits are resolved. With STAGES=1, the whole chain is in one stage.
- Boundary cases:
  - All-zeros maps to all-zeros in both modes.
  - MSB-only Gray (e.g. 8'h80) maps to all-ones binary.
  - The mode may change on every word; each word is converted only by its own mode.
  - Simultaneous accept at input and output with a full pipeline is legal and keeps occupancy constant.

Optional Feature:
- Macro: GB_ADJ_CHECK_EN.
- Defined:
  - A register holds the last accepted G2B input word plus a "seen" bit; both clear on reset.
  - For each accepted G2B word with seen=1, the flag is set if popcount(in_data ^ last) != 1; this includes identical words.
  - The flag travels down the pipeline with the word and drives out_adj_err alongside out_valid.
  - B2G words do not update the history and always carry flag 0. The first G2B word after reset carries flag 0.
- Undefined: the out_adj_err port, history register and popcount logic are absent. All other behaviour is identical.

Decomposition:
- Package gb_conv_pkg:
  - mode constants MODE_G2B=1'b0 and MODE_B2G=1'b1;
  - a chunk-width helper function ceil_div;
  - a pure function bin2gray.
- Sub-module gb_conv_stage: one pipeline register stage with valid/ready, data, mode and the optional flag. It is parametrised by WIDTH, a resolve-range high index and a low index, and performs the partial G2B resolution or passthrough. The top instantiates STAGES copies in a generate loop.

Test Plan:
- WIDTH=4, STAGES=2, out_ready=1; send G2B 4'b1011 -> 4'b1101 with out_mode=0 exactly 2 cycles after accept. Then send B2G 4'b1101 -> 4'b1011 with out_mode=1.
- WIDTH=8, STAGES=3; send a G2B stream 8'h80, 8'h00, 8'hFF back-to-back -> outputs 8'hFF, 8'h00, 8'hAA in order, one per cycle after 3-cycle fill.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready falls after STAGES words are accepted. out_data stays stable throughout. Releasing out_ready drains all words with none lost or duplicated.
- Reset mid-stream: assert rst_n low with 2 words in flight -> out_valid=0 and in_ready=0 immediately (asynchronously). No stale word appears after release.
- Randomised mode/data on every word with random out_ready, WIDTH=8, STAGES=1 and STAGES=8 -> every output equals the reference model in order.
- GB_ADJ_CHECK_EN defined: send G2B 8'h00, 8'h01, 8'h03, 8'h00 -> out_adj_err = 0, 0, 0, 1. An interleaved B2G word leaves the sequence unchanged.
